// File: rtl/slc3_mem_pkg.sv
// Shared types for the SLC-3 memory/IO bridge: FSM state encoding and the
// default memory-mapped switch/hex address.
package slc3_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MEM_WR,
      MEM_RD,
      RD_WAIT,
      DONE
   } state_t;

   localparam logic [15:0] DEF_IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/mem_io_bridge_sw_sync.sv
// Two-flop synchronizer for the board switches (used only when SW_SYNC_EN is
// defined). Synchronous active-low reset clears both stages.
module sw_sync #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-to-BRAM bridge with one memory-mapped switch/hex register at IO_ADDR.
// Define SW_SYNC_EN to route sw_i through a two-flop synchronizer.
module mem_io_bridge
   import slc3_mem_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [15:0] IO_ADDR    = DEF_IO_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_mem_ena,
   input  logic        mem_wr_ena,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic [15:0] cpu_rdata,
   output logic        mem_ready,
   output logic        bram_en,
   output logic        bram_we,
   output logic [15:0] bram_addr,
   output logic [15:0] bram_wdata,
   input  logic [15:0] bram_rdata,
   input  logic [15:0] sw_i,
   output logic [15:0] hex_o
);

   localparam int CW = $clog2(RD_LATENCY + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [15:0]   sw_s;

`ifdef SW_SYNC_EN
   sw_sync #(.W(16)) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw_i),
      .q     (sw_s)
   );
`else
   assign sw_s = sw_i;
`endif

   // Request fields are captured into the BRAM address/data registers at
   // acceptance, so later CPU-side changes cannot disturb an access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         cpu_rdata  <= '0;
         mem_ready  <= 1'b0;
         bram_en    <= 1'b0;
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         hex_o      <= '0;
      end else begin
         mem_ready <= 1'b0;
         bram_en   <= 1'b0;
         bram_we   <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_mem_ena) begin
                  if (mem_addr == IO_ADDR) begin
                     if (mem_wr_ena) hex_o     <= mem_wdata;
                     else            cpu_rdata <= sw_s;
                     state <= DONE;
                  end else begin
                     bram_addr  <= mem_addr;
                     bram_wdata <= mem_wdata;
                     bram_en    <= 1'b1;
                     bram_we    <= mem_wr_ena;
                     state      <= mem_wr_ena ? MEM_WR : MEM_RD;
                  end
               end
            end
            MEM_WR: state <= DONE;
            MEM_RD: begin
               cnt   <= CW'(RD_LATENCY);
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               // Last wait cycle: BRAM output is valid for the captured address.
               if (cnt <= CW'(1)) begin
                  cpu_rdata <= bram_rdata;
                  cnt       <= '0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               mem_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: two instances (RD_LATENCY 1 and 3), each with a
// behavioural BRAM; directed table, hand sequences, then random accesses.
module tb_mem_io_bridge;
   import slc3_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ena   [2];
   logic        wr    [2];
   logic [15:0] addr  [2];
   logic [15:0] wdata [2];
   logic [15:0] sw    [2];
   logic [15:0] rdata [2];
   logic        ready [2];
   logic        ben   [2];
   logic        bwe   [2];
   logic [15:0] baddr [2];
   logic [15:0] bwdata[2];
   logic [15:0] brdata[2];
   logic [15:0] hex   [2];

   always #5 clk = ~clk;

   mem_io_bridge #(.RD_LATENCY(1)) dut0 (
      .clk(clk), .reset(reset), .mem_mem_ena(ena[0]), .mem_wr_ena(wr[0]),
      .mem_addr(addr[0]), .mem_wdata(wdata[0]), .cpu_rdata(rdata[0]),
      .mem_ready(ready[0]), .bram_en(ben[0]), .bram_we(bwe[0]),
      .bram_addr(baddr[0]), .bram_wdata(bwdata[0]), .bram_rdata(brdata[0]),
      .sw_i(sw[0]), .hex_o(hex[0])
   );

   mem_io_bridge #(.RD_LATENCY(3)) dut1 (
      .clk(clk), .reset(reset), .mem_mem_ena(ena[1]), .mem_wr_ena(wr[1]),
      .mem_addr(addr[1]), .mem_wdata(wdata[1]), .cpu_rdata(rdata[1]),
      .mem_ready(ready[1]), .bram_en(ben[1]), .bram_we(bwe[1]),
      .bram_addr(baddr[1]), .bram_wdata(bwdata[1]), .bram_rdata(brdata[1]),
      .sw_i(sw[1]), .hex_o(hex[1])
   );

   // Behavioural BRAMs with 1- and 3-cycle registered read paths.
   logic [15:0] ram0 [65536];
   logic [15:0] ram1 [65536];
   logic [15:0] p0;
   logic [15:0] p1 [3];

   always @(posedge clk) begin
      if (ben[0] && bwe[0]) ram0[baddr[0]] <= bwdata[0];
      if (ben[1] && bwe[1]) ram1[baddr[1]] <= bwdata[1];
      p0    <= ram0[baddr[0]];
      p1[0] <= ram1[baddr[1]];
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end
   assign brdata[0] = p0;
   assign brdata[1] = p1[2];

   // Reference model: what the CPU should observe, from the access rules only.
   logic [15:0] mmem  [2][64];
   bit          wrote [2][64];
   logic [15:0] m_hex [2];
   logic [15:0] m_rd  [2];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input int d, input logic w, input logic [15:0] a,
                         input logic [15:0] wd, input bit scr,
                         output int lat, output int en_cyc, output int we_cyc,
                         output logic [15:0] seen_a, output logic [15:0] seen_wd);
      @(negedge clk);
      ena[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
      tick();
      lat = -1; en_cyc = 0; we_cyc = 0; seen_a = '0; seen_wd = '0;
      for (int k = 1; k <= 20; k++) begin
         if (ben[d]) begin
            en_cyc++;
            seen_a = baddr[d];
         end
         if (bwe[d]) begin
            we_cyc++;
            seen_wd = bwdata[d];
         end
         if (scr) begin
            addr[d] = 16'($urandom_range(16'hFFFE, 0)); wdata[d] = 16'($urandom); wr[d] = 1'($urandom);
         end
         tick();
         if (ready[d]) begin
            lat = k;
            break;
         end
      end
      ena[d] = 1'b0; wr[d] = 1'b0;
   endtask

   task automatic run(input int d, input logic w, input logic [15:0] a,
                      input logic [15:0] wd, input bit scr);
      int lat, en_cyc, we_cyc, exp_lat;
      logic [15:0] seen_a, seen_wd;
      bit io;
      io = (a == DEF_IO_ADDR);
      exp_lat = io ? 1 : (w ? 2 : 2 + (d == 1 ? 3 : 1));
      access(d, w, a, wd, scr, lat, en_cyc, we_cyc, seen_a, seen_wd);
      if (io && w)       m_hex[d] = wd;
      else if (io)       m_rd[d]  = sw[d];
      else if (w) begin
         mmem[d][a[5:0]]  = wd;
         wrote[d][a[5:0]] = 1'b1;
      end else           m_rd[d]  = mmem[d][a[5:0]];
      chk("latency", lat, exp_lat);
      chk("bram_en_cycles", en_cyc, io ? 0 : 1);
      chk("bram_we_cycles", we_cyc, (!io && w) ? 1 : 0);
      if (!io) chk("bram_addr", {16'h0, seen_a}, {16'h0, a});
      if (!io) chk("bram_addr_hold", {16'h0, baddr[d]}, {16'h0, a});
      if (!io && w) chk("bram_wdata", {16'h0, seen_wd}, {16'h0, wd});
      chk("cpu_rdata", {16'h0, rdata[d]}, {16'h0, m_rd[d]});
      chk("hex_o", {16'h0, hex[d]}, {16'h0, m_hex[d]});
      tick();
      chk("ready_one_pulse", {31'h0, ready[d]}, 32'h0);
   endtask

   typedef struct {
      int          d;
      logic        w;
      logic [15:0] a;
      logic [15:0] wd;
      logic [15:0] swv;
      bit          scr;
      logic [15:0] exp_rd;
      logic [15:0] exp_hex;
   } vec_t;

   vec_t vt [10];

   int          d, kind;
   logic [15:0] a, v;

   initial begin
      vt[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      vt[1] = '{0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 16'h0000};
      vt[2] = '{0, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 16'hBEEF, 16'h1234};
      vt[3] = '{0, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 1'b0, 16'h00A5, 16'h1234};
      vt[4] = '{1, 1'b1, 16'h0005, 16'h5A5A, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      vt[5] = '{1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 16'h0000};
      vt[6] = '{1, 1'b1, 16'h0020, 16'h7777, 16'h0000, 1'b0, 16'h5A5A, 16'h0000};
      vt[7] = '{1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 16'h0000};
      vt[8] = '{0, 1'b1, 16'h0010, 16'h1111, 16'h00A5, 1'b0, 16'h00A5, 16'h1234};
      vt[9] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000};

      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ena[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; sw[i] = '0;
         m_hex[i] = '0; m_rd[i] = '0;
      end
      repeat (3) tick();
      for (int i = 0; i < 2; i++)
         chk("reset_outputs",
             {ready[i], ben[i], bwe[i], 13'h0, rdata[i] | baddr[i] | bwdata[i] | hex[i]}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Directed table: sw is settled several cycles before each access.
      for (int i = 0; i < 10; i++) begin
         sw[vt[i].d] = vt[i].swv;
         repeat (3) tick();
         run(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, vt[i].scr);
         chk("tbl_rdata", {16'h0, rdata[vt[i].d]}, {16'h0, vt[i].exp_rd});
         chk("tbl_hex", {16'h0, hex[vt[i].d]}, {16'h0, vt[i].exp_hex});
      end

      // Request held high across completion: second access starts in the next IDLE cycle.
      @(negedge clk);
      ena[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'hFFFF; wdata[0] = 16'hAAAA;
      tick();
      wdata[0] = 16'hBBBB;
      chk("b2b_hex_first", {16'h0, hex[0]}, 32'h0000AAAA);
      tick();
      chk("b2b_ready_first", {31'h0, ready[0]}, 32'h1);
      tick();
      chk("b2b_ready_gap", {31'h0, ready[0]}, 32'h0);
      chk("b2b_hex_second", {16'h0, hex[0]}, 32'h0000BBBB);
      ena[0] = 1'b0; wr[0] = 1'b0;
      tick();
      chk("b2b_ready_second", {31'h0, ready[0]}, 32'h1);
      tick();
      chk("b2b_ready_end", {31'h0, ready[0]}, 32'h0);
      m_hex[0] = 16'hBBBB;

      // Reset held three cycles in the middle of a read aborts it silently.
      @(negedge clk);
      ena[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0010;
      tick();
      tick();
      @(negedge clk);
      reset = 1'b0; ena[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_mid_ready", {31'h0, ready[0]}, 32'h0);
      end
      chk("rst_mid_outputs",
          {ben[0], bwe[0], 14'h0, rdata[0] | baddr[0] | bwdata[0] | hex[0]}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_hex[i] = '0; m_rd[i] = '0;
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post_rst_no_ready", {31'h0, ready[0]}, 32'h0);
      end
      run(0, 1'b0, 16'h0010, 16'h0000, 1'b0);

      // Random accesses against the model.
      for (int i = 0; i < 150; i++) begin
         d    = $urandom_range(1, 0);
         kind = $urandom_range(3, 0);
         a    = 16'($urandom_range(63, 0));
         v    = 16'($urandom);
         if (kind == 3 && !wrote[d][a[5:0]]) kind = 2;
         case (kind)
            0: begin
               sw[d] = v;
               repeat (3) tick();
               run(d, 1'b0, 16'hFFFF, 16'($urandom), 1'b0);
            end
            1: run(d, 1'b1, 16'hFFFF, v, 1'($urandom));
            2: run(d, 1'b1, a, v, 1'($urandom));
            default: run(d, 1'b0, a, v, 1'($urandom));
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
